// File: rtl/onewire_txn_sequencer_if.sv
// Host command, read-byte stream and bit-engine signals of the 1-wire transaction sequencer.
// The sequencer connects through the slave modport; the host and bit-engine side uses master.
interface onewire_txn_sequencer_if #(
  parameter int RD_LEN_W = 4
);
  logic                start;
  logic [7:0]          cmd_rom;
  logic [7:0]          cmd_func;
  logic                two_cmd;
  logic [RD_LEN_W-1:0] rd_len;
  logic                busy;
  logic                done;
  logic                no_pres;
  logic                crc_ok;
  logic [7:0]          rx_data;
  logic                rx_valid;
  logic                rx_ready;
  logic                bit_req;
  logic [1:0]          bit_op;
  logic                bit_wdata;
  logic                bit_done;
  logic                bit_rdata;
  logic                bit_pres;

  modport master (
    output start, cmd_rom, cmd_func, two_cmd, rd_len, rx_ready,
           bit_done, bit_rdata, bit_pres,
    input  busy, done, no_pres, crc_ok, rx_data, rx_valid,
           bit_req, bit_op, bit_wdata
  );

  modport slave (
    input  start, cmd_rom, cmd_func, two_cmd, rd_len, rx_ready,
           bit_done, bit_rdata, bit_pres,
    output busy, done, no_pres, crc_ok, rx_data, rx_valid,
           bit_req, bit_op, bit_wdata
  );
endinterface

// File: rtl/onewire_txn_sequencer.sv
// 1-wire transaction sequencer: RESET/presence with retries, one or two command bytes,
// then up to 2^RD_LEN_W-1 read bytes streamed out with a running Dallas CRC8 check.
module onewire_txn_sequencer #(
  parameter int PRES_RETRIES = 2,
  parameter int RD_LEN_W     = 4
) (
  input logic clk,
  input logic reset,
  onewire_txn_sequencer_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_TX,
    S_RX,
    S_HOLD,
    S_DONE
  } state_e;

  localparam logic [2:0] MAX_RETRY = 3'(PRES_RETRIES);
  localparam logic [1:0] OP_RST    = 2'b00;
  localparam logic [1:0] OP_WR     = 2'b01;
  localparam logic [1:0] OP_RD     = 2'b10;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                no_pres_q;
  logic                crc_ok_q;
  logic [7:0]          rx_data_q;
  logic                rx_valid_q;
  logic                bit_req_q;
  logic [1:0]          bit_op_q;
  logic                bit_wdata_q;
  logic [7:0]          crc_q;
  logic [2:0]          retry_q;
  logic [2:0]          bit_cnt_q;
  logic [7:0]          tx_shift_q;
  logic [7:0]          rx_shift_q;
  logic [7:0]          cmd_func_q;
  logic                two_cmd_q;
  logic                second_q;
  logic [RD_LEN_W-1:0] rd_len_q;
  logic [RD_LEN_W-1:0] remain_q;

  logic                crc_fb;
  logic [7:0]          crc_d;
  logic [7:0]          rx_byte_d;
  logic                op_done;

  // Reflected CRC8 (0x8C) step and LSB-first byte assembly for the bit being returned
  always_comb begin
    crc_fb = crc_q[0] ^ bus_if.bit_rdata;
    crc_d  = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
  end

  assign rx_byte_d = {bus_if.bit_rdata, rx_shift_q[7:1]};
  assign op_done   = bit_req_q && bus_if.bit_done;

  // Each engine op: raise bit_req with op/wdata, drop it after bit_done, then one idle
  // cycle naturally follows because a new request is only raised while bit_req_q is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      no_pres_q   <= 1'b0;
      crc_ok_q    <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      bit_req_q   <= 1'b0;
      bit_op_q    <= OP_RST;
      bit_wdata_q <= 1'b0;
      crc_q       <= 8'h00;
      retry_q     <= 3'd0;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      cmd_func_q  <= 8'h00;
      two_cmd_q   <= 1'b0;
      second_q    <= 1'b0;
      rd_len_q    <= '0;
      remain_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus_if.start && !done_q) begin
            tx_shift_q  <= bus_if.cmd_rom;
            cmd_func_q  <= bus_if.cmd_func;
            two_cmd_q   <= bus_if.two_cmd;
            rd_len_q    <= bus_if.rd_len;
            no_pres_q   <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_q       <= 8'h00;
            retry_q     <= 3'd0;
            bit_cnt_q   <= 3'd0;
            second_q    <= 1'b0;
            busy_q      <= 1'b1;
            bit_req_q   <= 1'b1;
            bit_op_q    <= OP_RST;
            bit_wdata_q <= 1'b0;
            state_q     <= S_RST;
          end
        end
        S_RST: begin
          if (!bit_req_q) begin
            bit_req_q   <= 1'b1;
            bit_op_q    <= OP_RST;
            bit_wdata_q <= 1'b0;
          end else if (op_done) begin
            bit_req_q <= 1'b0;
            if (bus_if.bit_pres) begin
              state_q <= S_TX;
            end else if (retry_q < MAX_RETRY) begin
              retry_q <= retry_q + 3'd1;
            end else begin
              no_pres_q <= 1'b1;
              state_q   <= S_DONE;
            end
          end
        end
        S_TX: begin
          if (!bit_req_q) begin
            bit_req_q   <= 1'b1;
            bit_op_q    <= OP_WR;
            bit_wdata_q <= tx_shift_q[0];
          end else if (op_done) begin
            bit_req_q  <= 1'b0;
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (two_cmd_q && !second_q) begin
                second_q   <= 1'b1;
                tx_shift_q <= cmd_func_q;
              end else if (rd_len_q != '0) begin
                remain_q <= rd_len_q;
                state_q  <= S_RX;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
        end
        S_RX: begin
          if (!bit_req_q) begin
            bit_req_q   <= 1'b1;
            bit_op_q    <= OP_RD;
            bit_wdata_q <= 1'b0;
          end else if (op_done) begin
            bit_req_q  <= 1'b0;
            rx_shift_q <= rx_byte_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= rx_byte_d;
              rx_valid_q <= 1'b1;
              state_q    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (rx_valid_q && bus_if.rx_ready) begin
            rx_valid_q <= 1'b0;
            remain_q   <= remain_q - RD_LEN_W'(1);
            state_q    <= (remain_q == RD_LEN_W'(1)) ? S_DONE : S_RX;
          end
        end
        S_DONE: begin
          if (no_pres_q) begin
            crc_ok_q <= 1'b0;
          end else if (rd_len_q == '0) begin
            crc_ok_q <= 1'b1;
          end else begin
            crc_ok_q <= (crc_q == 8'h00);
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.no_pres   = no_pres_q;
  assign bus_if.crc_ok    = crc_ok_q;
  assign bus_if.rx_data   = rx_data_q;
  assign bus_if.rx_valid  = rx_valid_q;
  assign bus_if.bit_req   = bit_req_q;
  assign bus_if.bit_op    = bit_op_q;
  assign bus_if.bit_wdata = bit_wdata_q;

endmodule

// File: tb/tb_onewire_txn_sequencer.sv
// Directed bench for the 1-wire transaction sequencer with a behavioural bit engine
// and a read-byte stream monitor.
module tb_onewire_txn_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  onewire_txn_sequencer_if #(.RD_LEN_W(4)) bus ();

  onewire_txn_sequencer #(
    .PRES_RETRIES(2),
    .RD_LEN_W    (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_if(bus)
  );

  int         total = 0;
  int         bad = 0;
  logic       presVal;
  logic [7:0] rdBytes[16];
  logic [2:0] opLog[$];
  logic [7:0] rxLog[$];
  int         doneCount = 0;
  int         rdBit = 0;
  int         pending = 0;
  logic [1:0] capOp = 2'b00;
  logic       opChanged = 1'b0;
  logic [7:0] curByte;

  // Bit engine: answers each request two cycles after seeing it and logs {op, wdata}
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.bit_done  <= 1'b0;
      bus.bit_rdata <= 1'b0;
      bus.bit_pres  <= 1'b0;
      pending = 0;
    end else begin
      if (bus.start && !bus.busy && !bus.done) begin
        opLog.delete();
        rdBit = 0;
        opChanged = 1'b0;
      end
      if (bus.bit_done) begin
        bus.bit_done <= 1'b0;
      end else if (pending > 0) begin
        if (bus.bit_op !== capOp || bus.bit_req !== 1'b1) opChanged = 1'b1;
        pending = pending - 1;
        if (pending == 0) begin
          bus.bit_done <= 1'b1;
          bus.bit_pres <= presVal;
          if (capOp == 2'b10) begin
            curByte = rdBytes[rdBit / 8];
            bus.bit_rdata <= curByte[rdBit % 8];
            rdBit = rdBit + 1;
          end
        end
      end else if (bus.bit_req) begin
        capOp = bus.bit_op;
        opLog.push_back({bus.bit_op, bus.bit_wdata});
        pending = 2;
      end
    end
  end

  // Host-side monitor of accepted read bytes and done pulses
  always @(posedge clk) begin
    if (!reset) begin
      if (bus.start && !bus.busy && !bus.done) rxLog.delete();
      if (bus.rx_valid && bus.rx_ready) rxLog.push_back(bus.rx_data);
      if (bus.done) doneCount = doneCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] rom, input logic [7:0] func,
                               input logic two, input logic [3:0] len);
    @(negedge clk);
    bus.cmd_rom  = rom;
    bus.cmd_func = func;
    bus.two_cmd  = two;
    bus.rd_len   = len;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int maxCycles);
    logic got;
    got = 1'b0;
    for (int i = 0; i < maxCycles && !got; i++) begin
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    checkOutput(tag, got, 1'b1);
  endtask

  function automatic logic [63:0] packRx();
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < rxLog.size() && i < 8; i++) r = {r[55:0], rxLog[i]};
    return r;
  endfunction

  function automatic int countOp(input logic [1:0] k);
    int n;
    n = 0;
    foreach (opLog[i]) if (opLog[i][2:1] == k) n++;
    return n;
  endfunction

  task automatic loadRom(input logic [7:0] lastByte);
    rdBytes[0] = 8'h02; rdBytes[1] = 8'h1C; rdBytes[2] = 8'hB8; rdBytes[3] = 8'h01;
    rdBytes[4] = 8'h00; rdBytes[5] = 8'h00; rdBytes[6] = 8'h00; rdBytes[7] = lastByte;
  endtask

  initial begin
    logic [63:0] opsP;
    logic [15:0] wP;
    logic [7:0]  held;
    logic        stallReq;
    logic        dataMoved;
    logic        got;
    int          doneBefore;

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.cmd_rom  = 8'h00;
    bus.cmd_func = 8'h00;
    bus.two_cmd  = 1'b0;
    bus.rd_len   = 4'd0;
    bus.rx_ready = 1'b1;
    presVal      = 1'b1;
    for (int i = 0; i < 16; i++) rdBytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_no_pres", bus.no_pres, 1'b0);
    checkOutput("rst_crc_ok", bus.crc_ok, 1'b0);
    checkOutput("rst_rx_valid", bus.rx_valid, 1'b0);
    checkOutput("rst_rx_data", bus.rx_data, 8'h00);
    checkOutput("rst_bit_req", bus.bit_req, 1'b0);
    checkOutput("rst_bit_op", bus.bit_op, 2'b00);
    checkOutput("rst_bit_wdata", bus.bit_wdata, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] skip rom + convert, with start while busy and at done");
    applyStimulus(8'hCC, 8'h44, 1'b1, 4'd0);
    checkOutput("t1_busy", bus.busy, 1'b1);
    checkOutput("t1_req_latency", bus.bit_req, 1'b1);
    checkOutput("t1_first_op", bus.bit_op, 2'b00);
    repeat (10) @(negedge clk);
    applyStimulus(8'h33, 8'h00, 1'b0, 4'd4);
    waitDone("t1_done", 2000);
    checkOutput("t1_crc_ok", bus.crc_ok, 1'b1);
    checkOutput("t1_no_pres", bus.no_pres, 1'b0);
    checkOutput("t1_busy_at_done", bus.busy, 1'b0);
    checkOutput("t1_op_count", opLog.size(), 17);
    opsP = '0;
    wP   = '0;
    for (int i = 0; i < opLog.size() && i < 17; i++) begin
      opsP = {opsP[61:0], opLog[i][2:1]};
      if (i > 0) wP[i-1] = opLog[i][0];
    end
    checkOutput("t1_op_order", opsP, 64'h0000_0000_5555_5555);
    checkOutput("t1_wdata", wP, 16'h44CC);
    checkOutput("t1_stable_op", opChanged, 1'b0);
    bus.cmd_rom = 8'h33;
    bus.two_cmd = 1'b0;
    bus.rd_len  = 4'd2;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
    checkOutput("t1_done_pulse_len", bus.done, 1'b0);
    checkOutput("t1_start_at_done_busy", bus.busy, 1'b0);
    checkOutput("t1_start_at_done_req", bus.bit_req, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("t1_no_new_ops", opLog.size(), 17);

    $display("[TB] read rom, good crc");
    loadRom(8'hA2);
    applyStimulus(8'h33, 8'h00, 1'b0, 4'd8);
    waitDone("t2_done", 3000);
    checkOutput("t2_rx_count", rxLog.size(), 8);
    checkOutput("t2_rx_bytes", packRx(), 64'h021C_B801_0000_00A2);
    checkOutput("t2_crc_ok", bus.crc_ok, 1'b1);
    checkOutput("t2_op_count", opLog.size(), 73);
    checkOutput("t2_rd_ops", countOp(2'b10), 64);
    checkOutput("t2_wr_ops", countOp(2'b01), 8);

    $display("[TB] read rom, bad crc");
    loadRom(8'hA3);
    applyStimulus(8'h33, 8'h00, 1'b0, 4'd8);
    waitDone("t3_done", 3000);
    checkOutput("t3_rx_bytes", packRx(), 64'h021C_B801_0000_00A3);
    checkOutput("t3_crc_ok", bus.crc_ok, 1'b0);

    $display("[TB] no presence");
    presVal = 1'b0;
    applyStimulus(8'hCC, 8'h00, 1'b0, 4'd3);
    waitDone("t4_done", 2000);
    checkOutput("t4_no_pres", bus.no_pres, 1'b1);
    checkOutput("t4_crc_ok", bus.crc_ok, 1'b0);
    checkOutput("t4_op_count", opLog.size(), 3);
    checkOutput("t4_reset_ops", countOp(2'b00), 3);
    checkOutput("t4_rx_count", rxLog.size(), 0);
    repeat (5) @(negedge clk);
    checkOutput("t4_no_pres_held", bus.no_pres, 1'b1);

    $display("[TB] backpressure");
    presVal      = 1'b1;
    rdBytes[0]   = 8'h5A;
    rdBytes[1]   = 8'hC3;
    bus.rx_ready = 1'b0;
    applyStimulus(8'hCC, 8'hBE, 1'b0, 4'd2);
    checkOutput("t5_no_pres_cleared", bus.no_pres, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (bus.rx_valid) got = 1'b1;
    end
    checkOutput("t5_first_valid", got, 1'b1);
    held      = bus.rx_data;
    stallReq  = 1'b0;
    dataMoved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.bit_req !== 1'b0) stallReq = 1'b1;
      if (bus.rx_data !== held || bus.rx_valid !== 1'b1) dataMoved = 1'b1;
    end
    checkOutput("t5_first_byte", held, 8'h5A);
    checkOutput("t5_no_req_in_stall", stallReq, 1'b0);
    checkOutput("t5_data_stable", dataMoved, 1'b0);
    checkOutput("t5_ops_at_stall", opLog.size(), 17);
    bus.rx_ready = 1'b1;
    waitDone("t5_done", 2000);
    checkOutput("t5_rx_bytes", packRx(), 64'h5AC3);
    checkOutput("t5_op_count", opLog.size(), 25);

    $display("[TB] reset during first read byte");
    loadRom(8'hA2);
    applyStimulus(8'h33, 8'h00, 1'b0, 4'd8);
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (opLog.size() >= 12) got = 1'b1;
    end
    checkOutput("t6_reached_read", got, 1'b1);
    doneBefore = doneCount;
    reset = 1'b1;
    #1;
    checkOutput("t6_req_dropped", bus.bit_req, 1'b0);
    checkOutput("t6_busy_dropped", bus.busy, 1'b0);
    checkOutput("t6_rx_valid_low", bus.rx_valid, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_no_done", doneCount, doneBefore);
    applyStimulus(8'h33, 8'h00, 1'b0, 4'd8);
    waitDone("t6_rerun_done", 3000);
    checkOutput("t6_rerun_bytes", packRx(), 64'h021C_B801_0000_00A2);
    checkOutput("t6_rerun_crc_ok", bus.crc_ok, 1'b1);
    checkOutput("t6_stable_op", opChanged, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onewire_txn_sequencer.md
Name: onewire_txn_sequencer

Overview:
Transaction-level controller for the 1-wire bit engine. It accepts one host command and sequences the engine through a fixed order: bus RESET with presence check, one or two command bytes written LSB-first, then up to 15 bytes read LSB-first. Read bytes are delivered over a valid/ready byte stream, and a Dallas CRC8 check runs over all read bytes. It sits between the host or register block and the bit engine, and is the only requester of that engine.

Parameters:
PRES_RETRIES, 2, extra RESET attempts after a failed presence check before flagging an error (0..7).
RD_LEN_W, 4, width of rd_len; maximum read length is 2^RD_LEN_W-1 bytes.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle command strobe; accepted only when busy=0
cmd_rom  input  8  first command byte (e.g. 0x33 READ ROM, 0xCC SKIP ROM)
cmd_func  input  8  second command byte; sent only if two_cmd=1
two_cmd  input  1  1: send cmd_rom then cmd_func; 0: send cmd_rom only
rd_len  input  RD_LEN_W  number of bytes to read after the command bytes
busy  output  1  high from the cycle after start is accepted until done
done  output  1  single-cycle pulse at end of transaction
no_pres  output  1  presence failed after all retries; held until next accepted start
crc_ok  output  1  CRC8 residue==0 over the read bytes; valid at done, held until next start
rx_data  output  8  read byte
rx_valid  output  1  rx_data valid; held until rx_ready
rx_ready  input  1  host accepts byte when rx_valid&&rx_ready
bit_req  output  1  request to the bit engine; held high until bit_done
bit_op  output  2  00 RESET/presence, 01 write slot, 10 read slot, 11 reserved (never driven)
bit_wdata  output  1  bit to write for op 01
bit_done  input  1  single-cycle completion pulse from the engine
bit_rdata  input  1  sampled bus bit; valid with bit_done for op 10
bit_pres  input  1  1 = slave presence detected; valid with bit_done for op 00

Behaviour:
- Reset (async): state=IDLE. busy, done, no_pres, rx_valid, bit_req and bit_wdata all 0. crc_ok=0, rx_data=0, bit_op=00. CRC register and counters cleared. Asserting reset mid-transaction abandons it immediately, with no done pulse; the bit engine is reset by the same signal.
- Engine handshake: bit_op and bit_wdata are set in the same cycle bit_req rises and stay stable while bit_req=1. bit_req drops in the cycle after bit_done is sampled high. The next bit_req rises no earlier than one cycle after the drop, so every op has at least one idle cycle between requests. bit_done while bit_req=0 is ignored.
- States:
  - IDLE: on start, latch cmd_rom, cmd_func, two_cmd and rd_len. Clear no_pres, crc_ok, CRC=0x00 and retry count; busy=1; go RST. start while busy=1 is ignored.
  - RST: issue op 00.
    - bit_pres=1: go TX.
    - bit_pres=0 and retry count<PRES_RETRIES: increment and reissue RST.
    - Otherwise: no_pres=1, go DONE.
  - TX: shift out the current byte LSB-first, 8 write ops. After cmd_rom, send cmd_func if two_cmd=1. Then go RX if rd_len≠0, else DONE.
  - RX: 8 read ops per byte, assembled LSB-first: first bit read is bit0. Every received bit also updates the CRC, reflected polynomial x^8+x^5+x^4+1 (0x8C): fb=crc[0]^bit; crc=crc>>1; if fb, crc^=0x8C. After bit 8, go HOLD.
  - HOLD: rx_data=byte, rx_valid=1. The next byte's first read op is not issued until rx_valid&&rx_ready. After handshake, rx_valid=0 next cycle. Decrement remaining count; if 0 go DONE, else RX.
  - DONE: crc_ok=(CRC==0x00) if at least 1 byte was read; crc_ok=1 if rd_len=0; crc_ok=0 if no_pres. done=1 for one cycle, busy=0, go IDLE. start in this same cycle is ignored.
- Latency: start to first bit_req is 1 cycle. Minimum transaction length is 1+Σ(op latency+2) cycles.
- rx_ready held high permanently means no stall; rx_ready low holds the bus idle between slots (legal on 1-wire).

Test Plan:
- SKIP ROM + CONVERT: start, cmd_rom=0xCC, cmd_func=0x44, two_cmd=1, rd_len=0, model returns bit_pres=1 -> op order is 00, then 16×01 with wdata 0,0,1,1,0,0,1,1,0,0,1,0,0,0,1,0; done after the last bit_done; crc_ok=1; no_pres=0.
- READ ROM: cmd_rom=0x33, two_cmd=0, rd_len=8, model returns bytes 0x02,0x1C,0xB8,0x01,0x00,0x00,0x00,0xA2 -> rx stream has the same 8 bytes in order; crc_ok=1. Repeat with last byte 0xA3 -> crc_ok=0.
- No presence: bit_pres=0 always, PRES_RETRIES=2 -> exactly 3 op-00 requests, no write ops, no_pres=1, done pulse, crc_ok=0.
- Backpressure: rd_len=2, rx_ready=0 for 20 cycles after the first rx_valid -> no bit_req during the stall; rx_data is stable; the second byte's reads start after the handshake.
- Reset during byte 1 of a read: bit_req=0, busy=0, rx_valid=0 immediately; no done. A new start afterwards runs a full transaction.
- start pulsed while busy, and start coincident with done -> both ignored; the current transaction is unaffected.
